debounce_bank: RTL and testbench
================================

DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent debounced inputs.
REQ-002 Parameter STABLE_SAMPLES, default 8: consecutive disagreeing samples required to flip an output.
REQ-003 Parameter TICK_DIV, default 1: clk cycles per sample tick (1 = sample every cycle).
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in  input  CHANNELS  raw asynchronous inputs (buttons/switches).
REQ-007 out  output  CHANNELS  debounced levels, registered.
REQ-008 rise  output  CHANNELS  one-cycle pulse when the matching out bit goes 0->1.
REQ-009 fall  output  CHANNELS  one-cycle pulse when the matching out bit goes 1->0.
REQ-010 any_change  output  1  registered OR of all rise and fall bits, same cycle as those bits.

Function
REQ-011 Each in bit SHALL pass through a 2-flop synchroniser; in_sync is the second flop.
REQ-012 A shared prescaler SHALL count 0..TICK_DIV-1, wrap to 0, and assert tick in the cycle its count equals TICK_DIV-1; with TICK_DIV=1, tick SHALL be constant 1.
REQ-013 Per channel, on a tick: if in_sync equals out, the counter SHALL clear to 0.
REQ-014 On a tick with in_sync differing from out and counter < STABLE_SAMPLES-1, the counter SHALL increment by 1.
REQ-015 On a tick with in_sync differing from out and counter == STABLE_SAMPLES-1, out SHALL take in_sync, the counter SHALL clear, and rise or fall SHALL assert for exactly that one registered cycle.
REQ-016 Off-tick cycles SHALL hold the counter and out; rise and fall SHALL be 0.
REQ-017 Counter width SHALL be max(1, clog2(STABLE_SAMPLES)); the counter SHALL never exceed STABLE_SAMPLES-1.
REQ-018 Latency with TICK_DIV=1: a clean step first captured at edge 0 SHALL change out at edge STABLE_SAMPLES+1.
REQ-019 A disagreement shorter than STABLE_SAMPLES consecutive samples SHALL leave out unchanged and SHALL leave the counter at 0 once the input agrees again.
REQ-020 With STABLE_SAMPLES=1, out SHALL follow in_sync on every tick.
REQ-021 Channels SHALL be fully independent; simultaneous flips on several channels SHALL produce all of their pulses in the same cycle.
REQ-022 rise and fall of one channel SHALL never be high together.

Reset
REQ-023 While rst is high at a clk edge, out, rise, fall, any_change, synchroniser flops, per-channel counters and prescaler SHALL all clear to 0.
REQ-024 rst asserted mid-count SHALL discard partial counts; counting SHALL restart from 0 on the first tick after release.
REQ-025 The first prescaler tick after reset release SHALL occur TICK_DIV cycles after release.

Structure
REQ-026 Shared package debounce_pkg SHALL hold the counter-width function and the default constants for STABLE_SAMPLES and TICK_DIV.
REQ-027 The per-channel logic (synchroniser, counter, out, rise, fall) SHALL be sub-module debounce_channel, instantiated CHANNELS times; the prescaler and any_change SHALL stay in debounce_bank.
REQ-028 Elaboration SHALL fail if CHANNELS < 1, STABLE_SAMPLES < 1 or TICK_DIV < 1.

Verification
REQ-029 Defaults, in[0] steps 0->1 cleanly -> out[0]=1 and rise[0] one cycle at edge 9, any_change=1 the same cycle, other channels at 0.
REQ-030 Defaults, in[1] glitches high for 7 cycles then low -> out[1], rise and any_change stay 0 throughout.
REQ-031 Defaults, in[2] bounces 1,0,1,1,0 then holds 1 -> exactly one rise[2], 8 cycles after the final 0->1 synchronised edge; then in[2]=0 held -> exactly one fall[2].
REQ-032 TICK_DIV=4, STABLE_SAMPLES=3, step on in[0] -> out[0] changes on the 3rd tick after in_sync changes; rise[0] width is 1 clk cycle, not 1 tick period.
REQ-033 Defaults, rst pulsed for 1 cycle after 5 disagreeing samples -> all outputs 0 the next cycle; out flips only after 8 fresh samples following release.
REQ-034 Defaults, all 4 inputs step together -> rise=4'b1111 for one cycle, any_change=1 for one cycle.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants and sizing helper for the debounce bank and its channels.
package debounce_pkg;

  localparam int DEF_CHANNELS       = 4;
  localparam int DEF_STABLE_SAMPLES = 8;
  localparam int DEF_TICK_DIV       = 1;

  // Counter width for a modulo-n count, never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: 2-flop synchroniser, agreement counter, registered level and edge pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall,
  output logic change_next
);

  localparam int CW = cnt_width(STABLE_SAMPLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_SAMPLES - 1);

  logic          sync_meta;
  logic          in_sync;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          out_next;
  logic          rise_next;
  logic          fall_next;
  logic          differ;
  logic          expire;

  always_comb begin
    differ    = (in_sync != out);
    expire    = tick && differ && (cnt == CNT_LAST);
    cnt_next  = cnt;
    out_next  = out;
    if (tick) begin
      if (!differ) begin
        cnt_next = '0;
      end else if (cnt == CNT_LAST) begin
        cnt_next = '0;
        out_next = in_sync;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end
    rise_next = expire && in_sync;
    fall_next = expire && !in_sync;
  end

  // Exposed so the bank can register any_change in the same cycle as the pulses.
  assign change_next = expire;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= 1'b0;
      in_sync   <= 1'b0;
      cnt       <= '0;
      out       <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
    end else begin
      sync_meta <= in;
      in_sync   <= sync_meta;
      cnt       <= cnt_next;
      out       <= out_next;
      rise      <= rise_next;
      fall      <= fall_next;
    end
  end

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounced inputs sharing one sample-tick prescaler.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int CHANNELS       = DEF_CHANNELS,
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
  parameter int TICK_DIV       = DEF_TICK_DIV
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                any_change
);

  localparam int PW = cnt_width(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  if (CHANNELS < 1) begin : g_bad_channels
    $error("debounce_bank: CHANNELS must be at least 1");
  end
  if (STABLE_SAMPLES < 1) begin : g_bad_samples
    $error("debounce_bank: STABLE_SAMPLES must be at least 1");
  end
  if (TICK_DIV < 1) begin : g_bad_div
    $error("debounce_bank: TICK_DIV must be at least 1");
  end

  logic                tick;
  logic [CHANNELS-1:0] change_next;

  if (TICK_DIV == 1) begin : g_no_div
    assign tick = 1'b1;
  end else begin : g_div
    logic [PW-1:0] pre_cnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        pre_cnt <= '0;
      end else if (pre_cnt == PRE_LAST) begin
        pre_cnt <= '0;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
    end

    assign tick = (pre_cnt == PRE_LAST);
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    debounce_channel #(
      .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .in         (in[c]),
      .out        (out[c]),
      .rise       (rise[c]),
      .fall       (fall[c]),
      .change_next(change_next[c])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      any_change <= 1'b0;
    end else begin
      any_change <= |change_next;
    end
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: three configurations checked every cycle against a sample-window model.
module tb_debounce_bank;

  localparam int ND = 3;
  localparam int SS_P [ND] = '{8, 3, 1};
  localparam int TD_P [ND] = '{1, 4, 1};
  localparam int CH_P [ND] = '{4, 4, 1};

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] in_a = '0;
  logic [3:0] in_b = '0;
  logic       in_c = 1'b0;
  logic [3:0] out_a, rise_a, fall_a;
  logic [3:0] out_b, rise_b, fall_b;
  logic       out_c, rise_c, fall_c;
  logic       any_a, any_b, any_c;

  int n_cmp = 0;
  int n_bad = 0;

  debounce_bank u_dut_a (
    .clk(clk), .rst(rst), .in(in_a),
    .out(out_a), .rise(rise_a), .fall(fall_a), .any_change(any_a)
  );

  debounce_bank #(.CHANNELS(4), .STABLE_SAMPLES(3), .TICK_DIV(4)) u_dut_b (
    .clk(clk), .rst(rst), .in(in_b),
    .out(out_b), .rise(rise_b), .fall(fall_b), .any_change(any_b)
  );

  debounce_bank #(.CHANNELS(1), .STABLE_SAMPLES(1), .TICK_DIV(1)) u_dut_c (
    .clk(clk), .rst(rst), .in(in_c),
    .out(out_c), .rise(rise_c), .fall(fall_c), .any_change(any_c)
  );

  logic [3:0] din [ND];
  logic [3:0] d_out [ND];
  logic [3:0] d_rise [ND];
  logic [3:0] d_fall [ND];
  logic       d_any [ND];

  always_comb begin
    din[0] = in_a;
    din[1] = in_b;
    din[2] = {3'b000, in_c};
    d_out[0] = out_a;  d_rise[0] = rise_a;  d_fall[0] = fall_a;  d_any[0] = any_a;
    d_out[1] = out_b;  d_rise[1] = rise_b;  d_fall[1] = fall_b;  d_any[1] = any_b;
    d_out[2] = {3'b000, out_c};
    d_rise[2] = {3'b000, rise_c};
    d_fall[2] = {3'b000, fall_c};
    d_any[2] = any_c;
  end

  task automatic chk(input string name, input int d, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %b expected %b at %0t", name, d, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: sync is a two-edge delay; sample ticks are every TD-th edge since reset;
  // an output flips when the last SS tick samples all disagree with it.
  logic [3:0] s1 [ND];
  logic [3:0] s2 [ND];
  logic [3:0] m_out [ND];
  logic [3:0] m_rise [ND];
  logic [3:0] m_fall [ND];
  logic       m_any [ND];
  int         cyc [ND];
  bit         hist [ND][4][$];
  bit         model_valid = 1'b0;
  bit         m_tick;
  bit         m_all;

  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (rst) begin
        s1[d] = '0; s2[d] = '0;
        m_out[d] = '0; m_rise[d] = '0; m_fall[d] = '0; m_any[d] = 1'b0;
        cyc[d] = 0;
        for (int c = 0; c < 4; c++) hist[d][c].delete();
      end else begin
        cyc[d]++;
        m_tick = (cyc[d] % TD_P[d]) == 0;
        m_rise[d] = '0;
        m_fall[d] = '0;
        if (m_tick) begin
          for (int c = 0; c < CH_P[d]; c++) begin
            hist[d][c].push_back(s2[d][c]);
            if (hist[d][c].size() > SS_P[d]) void'(hist[d][c].pop_front());
            m_all = (hist[d][c].size() == SS_P[d]);
            for (int i = 0; i < hist[d][c].size(); i++)
              if (hist[d][c][i] == m_out[d][c]) m_all = 1'b0;
            if (m_all) begin
              m_out[d][c] = ~m_out[d][c];
              if (m_out[d][c]) m_rise[d][c] = 1'b1;
              else             m_fall[d][c] = 1'b1;
            end
          end
        end
        m_any[d] = (|m_rise[d]) || (|m_fall[d]);
        s2[d] = s1[d];
        s1[d] = din[d];
      end
    end
    if (rst) model_valid = 1'b1;
  end

  // scoreboard compare
  always @(negedge clk) begin
    if (model_valid) begin
      for (int d = 0; d < ND; d++) begin
        chk("out", d, d_out[d], m_out[d]);
        chk("rise", d, d_rise[d], m_rise[d]);
        chk("fall", d, d_fall[d], m_fall[d]);
        chk("any_change", d, {3'b000, d_any[d]}, {3'b000, m_any[d]});
        chk("rise_fall_excl", d, d_rise[d] & d_fall[d], 4'b0000);
      end
    end
  end

  // stimulus
  initial begin
    logic [4:0] bounce;
    bit saw;
    int nr, rk, nf;

    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Divided-tick and single-sample configurations, timed from reset release.
    in_b[0] = 1'b1;
    in_c    = 1'b1;
    rst     = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 2)  chk("ss1_before", 2, {3'b000, out_c}, 4'b0000);
      if (k == 3)  chk("ss1_flip", 2, {3'b000, out_c}, 4'b0001);
      if (k == 11) chk("div_before", 1, out_b, 4'b0000);
      if (k == 12) begin
        chk("div_flip", 1, out_b, 4'b0001);
        chk("div_rise", 1, rise_b, 4'b0001);
      end
      if (k == 13) chk("div_rise_width", 1, rise_b, 4'b0000);
    end
    repeat (5) @(negedge clk);

    // Clean step on channel 0.
    in_a[0] = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k == 8) chk("step_before", 0, out_a, 4'b0000);
      if (k == 9) begin
        chk("step_out", 0, out_a, 4'b0001);
        chk("step_rise", 0, rise_a, 4'b0001);
        chk("step_any", 0, {3'b000, any_a}, 4'b0001);
      end
      if (k == 10) begin
        chk("step_rise_end", 0, rise_a, 4'b0000);
        chk("step_any_end", 0, {3'b000, any_a}, 4'b0000);
      end
    end

    // Seven-cycle glitch on channel 1.
    saw = 1'b0;
    in_a[1] = 1'b1;
    for (int k = 0; k < 32; k++) begin
      if (k == 7) in_a[1] = 1'b0;
      @(negedge clk);
      saw = saw | out_a[1] | rise_a[1] | any_a;
    end
    chk("glitch_quiet", 0, {3'b000, saw}, 4'b0000);

    // Bouncing step on channel 2, then a clean release.
    bounce = 5'b01101;
    for (int i = 0; i < 5; i++) begin
      in_a[2] = bounce[i];
      @(negedge clk);
    end
    in_a[2] = 1'b1;
    nr = 0; rk = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (rise_a[2]) begin nr++; rk = k; end
    end
    chk_int("bounce_rise_count", nr, 1);
    chk_int("bounce_rise_edge", rk, 9);
    in_a[2] = 1'b0;
    nf = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (fall_a[2]) nf++;
    end
    chk_int("bounce_fall_count", nf, 1);

    // Reset mid-count discards the partial count.
    in_a = 4'b0000;
    repeat (20) @(negedge clk);
    in_a[3] = 1'b1;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_out", 0, out_a, 4'b0000);
    chk("rst_rise", 0, rise_a, 4'b0000);
    chk("rst_fall", 0, fall_a, 4'b0000);
    chk("rst_any", 0, {3'b000, any_a}, 4'b0000);
    chk("rst_out_div", 1, out_b, 4'b0000);
    rst = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      if (k == 8) chk("rst_restart_before", 0, out_a, 4'b0000);
      if (k == 9) begin
        chk("rst_restart_out", 0, out_a, 4'b1000);
        chk("rst_restart_rise", 0, rise_a, 4'b1000);
      end
    end

    // All channels step together.
    in_a = 4'b0000;
    repeat (20) @(negedge clk);
    in_a = 4'b1111;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k == 9) begin
        chk("all_rise", 0, rise_a, 4'b1111);
        chk("all_any", 0, {3'b000, any_a}, 4'b0001);
      end
      if (k == 10) begin
        chk("all_rise_end", 0, rise_a, 4'b0000);
        chk("all_any_end", 0, {3'b000, any_a}, 4'b0000);
      end
    end

    // Random bouncing with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 499) == 0);
      for (int c = 0; c < 4; c++)
        if ($urandom_range(0, 5) == 0) in_a[c] = ~in_a[c];
      for (int c = 0; c < 4; c++)
        if ($urandom_range(0, 19) == 0) in_b[c] = ~in_b[c];
      if ($urandom_range(0, 2) == 0) in_c = ~in_c;
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
